// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   // Fetch controller states
   typedef enum logic [1:0] {
      START  = 2'd0,
      FETCH  = 2'd1,
      REFILL = 2'd2
   } if_state_e;

   // Bytes per instruction; sequential fetch advances by this amount
   localparam int unsigned INST_BYTES = 4;

   // Widest word supported; ZERO_WORD is sliced down to XLEN by users
   localparam int unsigned WORD_MAX_W = 64;
   localparam logic [WORD_MAX_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_fetch_queue_if_queue.sv
// if_queue: synchronous FIFO of {pc, inst} pairs with flush, push, pop,
// occupancy count and registered head outputs. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module if_queue
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic [XLEN-1:0]         push_pc_i,
   input  logic [XLEN-1:0]         push_inst_i,
   input  logic                    pop,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    empty_o,
   output logic [XLEN-1:0]         head_pc_o,
   output logic [XLEN-1:0]         head_inst_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointer, count and storage update; flush discards everything queued
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = '{pc: push_pc_i, inst: push_inst_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: pointers and count are reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries data only and needs no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count_o     = count_q;
   assign empty_o     = (count_q == '0);
   assign head_pc_o   = mem_q[rd_ptr_q].pc;
   assign head_inst_o = mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Streams sequential addresses to the I-cache, buffers {pc, inst} pairs and
// presents one instruction per cycle to ID. Redirects from ID flush the queue;
// a redirect during a cache miss is held pending until the miss resolves so
// the address seen by the cache never changes mid-miss.
// Optional feature macro: IFQ_BYPASS_EN -- when defined, a hit into an empty
// queue is forwarded to the outputs in the same cycle.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_o,
   output logic [XLEN-1:0] addr_o,
   input  logic [XLEN-1:0] data_i,
   input  logic            miss_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            stall_i,
   output logic            valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o
);

   localparam int unsigned     CNT_W = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] ZW    = ZERO_WORD[XLEN-1:0];
   localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);

   if_state_e        state_q, state_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic             pend_vld_q, pend_vld_d;
   logic [XLEN-1:0]  pend_pc_q, pend_pc_d;

   logic             req;
   logic             accept;
   logic             byp;
   logic             q_flush, q_push, q_pop, q_empty;
   logic [CNT_W-1:0] q_count;
   logic [XLEN-1:0]  q_head_pc, q_head_inst;

   if_queue #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush       (q_flush),
      .push        (q_push),
      .push_pc_i   (addr_q),
      .push_inst_i (data_i),
      .pop         (q_pop),
      .count_o     (q_count),
      .empty_o     (q_empty),
      .head_pc_o   (q_head_pc),
      .head_inst_o (q_head_inst)
   );

   // Next state, fetch address, pending redirect and queue control
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
      req        = 1'b0;
      accept     = 1'b0;
      byp        = 1'b0;
      q_flush    = 1'b0;
      q_push     = 1'b0;
      q_pop      = 1'b0;

      // req_o uses the registered count, so a full queue being drained this
      // cycle still holds off the request until the next cycle
      unique case (state_q)
         FETCH:   req = (q_count != CNT_W'(DEPTH));
         REFILL:  req = 1'b1;
         default: req = 1'b0;
      endcase

      if (redirect_i) begin
         q_flush = 1'b1;
         if ((state_q == REFILL) && miss_i) begin
            // Cache is still busy with addr_o: remember the target, last one wins
            pend_vld_d = 1'b1;
            pend_pc_d  = redirect_pc_i;
         end else begin
            addr_d     = redirect_pc_i;
            pend_vld_d = 1'b0;
            state_d    = FETCH;
         end
      end else begin
         unique case (state_q)
            START: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (req && miss_i) begin
                  state_d = REFILL;
               end else if (req) begin
                  accept = 1'b1;
               end
            end
            REFILL: begin
               if (!miss_i) begin
                  state_d = FETCH;
                  if (pend_vld_q) begin
                     // Response belongs to the abandoned path; drop it
                     addr_d     = pend_pc_q;
                     pend_vld_d = 1'b0;
                  end else begin
                     accept = 1'b1;
                  end
               end
            end
            default: begin
               state_d = START;
            end
         endcase

         if (accept) begin
            addr_d = addr_q + STEP;
         end

         q_pop = !q_empty && !stall_i;
`ifdef IFQ_BYPASS_EN
         byp    = accept && q_empty;
         q_push = accept && !(byp && !stall_i);
`else
         q_push = accept;
`endif
      end
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= START;
         addr_q     <= RESET_PC;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   // Pending redirect target is only meaningful while pend_vld_q is set
   always_ff @(posedge clk) begin
      pend_pc_q <= pend_pc_d;
   end

   // ID-side outputs: queue head, or the forwarded hit when bypassing
   always_comb begin
      valid_o = 1'b0;
      inst_o  = ZW;
      pc_o    = ZW;
      if (!q_empty) begin
         valid_o = 1'b1;
         inst_o  = q_head_inst;
         pc_o    = q_head_pc;
      end else if (byp) begin
         valid_o = 1'b1;
         inst_o  = data_i;
         pc_o    = addr_q;
      end
   end

   assign req_o  = req;
   assign addr_o = addr_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (default build, DEPTH=4).
module tb_if_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_o;
   logic [31:0] addr_o;
   logic [31:0] data_i = '0;
   logic        miss_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        stall_i = 1'b0;
   logic        valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   if_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_o         (req_o),
      .addr_o        (addr_o),
      .data_i        (data_i),
      .miss_i        (miss_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .stall_i       (stall_i),
      .valid_o       (valid_o),
      .inst_o        (inst_o),
      .pc_o          (pc_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instruction memory contents as seen through the cache
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue of fetched words plus fetch pointer
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_addr;
   bit          m_started, m_miss, m_pend;
   logic [31:0] m_pend_pc;

   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_inst;

   task automatic model_reset();
      mq.delete();
      m_addr    = 32'h0;
      m_started = 1'b0;
      m_miss    = 1'b0;
      m_pend    = 1'b0;
      m_pend_pc = 32'h0;
   endtask

   // One clock cycle: drive inputs, sample and check at negedge, advance model
   task automatic step(input bit r, input logic [31:0] rpc, input bit st, input bit ms);
      bit          e_req, e_valid, pop;
      logic [31:0] e_pc, e_inst;
      redirect_i    = r;
      redirect_pc_i = rpc;
      stall_i       = st;
      miss_i        = ms;
      data_i        = mem_word(addr_o);
      @(negedge clk);
      s_req   = req_o;
      s_addr  = addr_o;
      s_valid = valid_o;
      s_pc    = pc_o;
      s_inst  = inst_o;

      e_req   = !m_started ? 1'b0 : (m_miss ? 1'b1 : (mq.size() < DEPTH));
      e_valid = (mq.size() > 0);
      e_pc    = e_valid ? mq[0].pc : 32'h0;
      e_inst  = e_valid ? mq[0].inst : 32'h0;
      chk("model_req", {31'b0, s_req}, {31'b0, e_req});
      chk("model_addr", s_addr, m_addr);
      chk("model_valid", {31'b0, s_valid}, {31'b0, e_valid});
      chk("model_pc", s_pc, e_pc);
      chk("model_inst", s_inst, e_inst);

      pop = e_valid && !st;
      if (r) begin
         mq.delete();
         if (m_started && m_miss && ms) begin
            m_pend    = 1'b1;
            m_pend_pc = rpc;
         end else begin
            m_addr = rpc;
            m_miss = 1'b0;
            m_pend = 1'b0;
         end
      end else if (m_started) begin
         if (pop) void'(mq.pop_front());
         if (m_miss) begin
            if (!ms) begin
               if (m_pend) begin
                  m_addr = m_pend_pc;
                  m_pend = 1'b0;
               end else begin
                  mq.push_back('{m_addr, mem_word(m_addr)});
                  m_addr = m_addr + 32'd4;
               end
               m_miss = 1'b0;
            end
         end else if (e_req) begin
            if (ms) begin
               m_miss = 1'b1;
            end else begin
               mq.push_back('{m_addr, mem_word(m_addr)});
               m_addr = m_addr + 32'd4;
            end
         end
      end
      m_started = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          r;
      logic [31:0] rpc;
      bit          st;
      bit          ms;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input bit r, input logic [31:0] rpc, input bit st, input bit ms,
                       input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                       input logic [31:0] e_pc);
      tbl.push_back('{r, rpc, st, ms, e_req, e_addr, e_valid, e_pc});
   endtask

   initial begin
      logic [31:0] e_inst;

      // Hits from reset, 10-cycle stall filling the queue, drain, redirect with 3 queued
      addv(0, 0, 0, 0, 0, 32'h00, 0, 32'h00);
      addv(0, 0, 0, 0, 1, 32'h00, 0, 32'h00);
      addv(0, 0, 0, 0, 1, 32'h04, 1, 32'h00);
      addv(0, 0, 0, 0, 1, 32'h08, 1, 32'h04);
      addv(0, 0, 0, 0, 1, 32'h0C, 1, 32'h08);
      addv(0, 0, 1, 0, 1, 32'h10, 1, 32'h0C);
      addv(0, 0, 1, 0, 1, 32'h14, 1, 32'h0C);
      addv(0, 0, 1, 0, 1, 32'h18, 1, 32'h0C);
      for (int k = 0; k < 7; k++) addv(0, 0, 1, 0, 0, 32'h1C, 1, 32'h0C);
      addv(0, 0, 0, 0, 0, 32'h1C, 1, 32'h0C);
      addv(0, 0, 0, 0, 1, 32'h1C, 1, 32'h10);
      addv(0, 0, 0, 0, 1, 32'h20, 1, 32'h14);
      addv(0, 0, 0, 0, 1, 32'h24, 1, 32'h18);
      addv(0, 0, 0, 0, 1, 32'h28, 1, 32'h1C);
      addv(0, 0, 0, 0, 1, 32'h2C, 1, 32'h20);
      addv(1, 32'h100, 0, 0, 1, 32'h30, 1, 32'h24);
      addv(0, 0, 0, 0, 1, 32'h100, 0, 32'h00);
      addv(0, 0, 0, 0, 1, 32'h104, 1, 32'h100);
      addv(0, 0, 0, 0, 1, 32'h108, 1, 32'h104);

      // Reset values while rst is held
      model_reset();
      @(negedge clk);
      chk("rst_req", {31'b0, req_o}, 32'h0);
      chk("rst_addr", addr_o, 32'h0);
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].rpc, tbl[i].st, tbl[i].ms);
         e_inst = tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 32'h0;
         chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].e_req});
         chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_inst", i), s_inst, e_inst);
      end

      // Address wrap-around at the top of the address space
      step(1, 32'hFFFF_FFF8, 0, 0);
      step(0, 0, 0, 0);
      chk("wrap_addr0", s_addr, 32'hFFFF_FFF8);
      chk("wrap_valid0", {31'b0, s_valid}, 32'h0);
      step(0, 0, 0, 0);
      chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
      chk("wrap_pc1", s_pc, 32'hFFFF_FFF8);
      step(0, 0, 0, 0);
      chk("wrap_addr2", s_addr, 32'h0);
      chk("wrap_pc2", s_pc, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      chk("wrap_pc3", s_pc, 32'h0);

      // Miss at 0x20 for 5 cycles with a redirect to 0x80 on its second cycle
      step(1, 32'h20, 0, 0);
      step(0, 0, 0, 1);
      chk("miss_addr1", s_addr, 32'h20);
      chk("miss_req1", {31'b0, s_req}, 32'h1);
      step(1, 32'h80, 0, 1);
      chk("miss_addr2", s_addr, 32'h20);
      for (int k = 3; k <= 5; k++) begin
         step(0, 0, 0, 1);
         chk($sformatf("miss_addr%0d", k), s_addr, 32'h20);
         chk($sformatf("miss_valid%0d", k), {31'b0, s_valid}, 32'h0);
      end
      step(0, 0, 0, 0);
      chk("miss_fall_addr", s_addr, 32'h20);
      step(0, 0, 0, 0);
      chk("miss_target_addr", s_addr, 32'h80);
      chk("miss_drop_valid", {31'b0, s_valid}, 32'h0);
      step(0, 0, 0, 0);
      chk("miss_first_valid", {31'b0, s_valid}, 32'h1);
      chk("miss_first_pc", s_pc, 32'h80);

      // Two redirects during one miss: the last one wins
      step(1, 32'h40, 0, 0);
      step(0, 0, 0, 1);
      step(1, 32'h80, 0, 1);
      step(1, 32'hC0, 0, 1);
      step(0, 0, 0, 0);
      chk("dbl_hold_addr", s_addr, 32'h40);
      step(0, 0, 0, 0);
      chk("dbl_addr", s_addr, 32'hC0);
      step(0, 0, 0, 0);
      chk("dbl_pc", s_pc, 32'hC0);

      // Redirect in the same cycle the miss falls
      step(0, 0, 0, 1);
      step(1, 32'h200, 0, 0);
      step(0, 0, 0, 0);
      chk("same_addr", s_addr, 32'h200);
      chk("same_valid", {31'b0, s_valid}, 32'h0);
      step(0, 0, 0, 0);
      chk("same_pc", s_pc, 32'h200);

      // Asynchronous reset in the middle of a refill with a loaded queue
      step(1, 32'h300, 1, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk("pre_rst_valid", {31'b0, s_valid}, 32'h1);
      chk("pre_rst_addr", s_addr, 32'h30C);
      rst = 1'b1;
      #1;
      chk("arst_req", {31'b0, req_o}, 32'h0);
      chk("arst_addr", addr_o, 32'h0);
      chk("arst_valid", {31'b0, valid_o}, 32'h0);
      chk("arst_inst", inst_o, 32'h0);
      chk("arst_pc", pc_o, 32'h0);
      miss_i  = 1'b0;
      stall_i = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 0, 0);
      chk("restart_req0", {31'b0, s_req}, 32'h0);
      step(0, 0, 0, 0);
      chk("restart_addr1", s_addr, 32'h0);
      step(0, 0, 0, 0);
      chk("restart_valid2", {31'b0, s_valid}, 32'h1);
      chk("restart_pc2", s_pc, 32'h0);

      // Randomised traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         bit          r, st, ms;
         logic [31:0] rpc;
         r   = ($urandom_range(0, 99) < 5);
         rpc = $urandom() & 32'hFFFF_FFFC;
         st  = ($urandom_range(0, 99) < 30);
         ms  = ($urandom_range(0, 99) < 20);
         step(r, rpc, st, ms);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
